// File: rtl/detection_scheduler.sv
// YOLO detection-head decode sequencer: walks grid cells and anchors, fetches the
// five box words from a 1-cycle-latency RAM and streams boxes passing the objectness threshold.
module detection_scheduler #(
  parameter int GRID_W = 13,
  parameter int GRID_H = 13,
  parameter int B      = 2,
  parameter int C      = 20,
  parameter int DW     = 16,
  parameter int AW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [DW-1:0] obj_thresh,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_x,
  output logic [DW-1:0] out_y,
  output logic [DW-1:0] out_w,
  output logic [DW-1:0] out_h,
  output logic [DW-1:0] out_obj,
  output logic [7:0]    out_cx,
  output logic [7:0]    out_cy,
  output logic [7:0]    out_box,
  output logic [15:0]   cand_count
);

  localparam logic [AW-1:0] STRIDE = AW'(5 + C);

  typedef enum logic [2:0] {IDLE, FETCH, LAST, CHECK, EMIT, DONE} state_t;

  state_t        state;
  logic [2:0]    k;
  logic [AW-1:0] box_addr;
  logic [DW-1:0] thr;
  logic          pass;
  logic          last_box;
  logic          do_adv;
  logic [7:0]    nxt_cx, nxt_cy, nxt_b;

  assign pass = $signed(out_obj) >= $signed(thr);

  // Row-major cell order with b fastest matches the linear box index, so the
  // box base address simply steps by the box stride on every advance.
  always_comb begin
    last_box = (out_box == 8'(B - 1)) && (out_cx == 8'(GRID_W - 1)) &&
               (out_cy == 8'(GRID_H - 1));
    do_adv   = ((state == CHECK) && !pass) || ((state == EMIT) && out_ready);
    nxt_b    = out_box;
    nxt_cx   = out_cx;
    nxt_cy   = out_cy;
    if (out_box == 8'(B - 1)) begin
      nxt_b = '0;
      if (out_cx == 8'(GRID_W - 1)) begin
        nxt_cx = '0;
        nxt_cy = out_cy + 8'd1;
      end else begin
        nxt_cx = out_cx + 8'd1;
      end
    end else begin
      nxt_b = out_box + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      box_addr   <= '0;
      thr        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_w      <= '0;
      out_h      <= '0;
      out_obj    <= '0;
      out_cx     <= '0;
      out_cy     <= '0;
      out_box    <= '0;
      cand_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            thr        <= obj_thresh;
            box_addr   <= base_addr;
            rd_addr    <= base_addr;
            rd_en      <= 1'b1;
            k          <= '0;
            out_cx     <= '0;
            out_cy     <= '0;
            out_box    <= '0;
            cand_count <= '0;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          // rd_data holds the word requested on the previous cycle (k-1)
          case (k)
            3'd1:    out_x <= rd_data;
            3'd2:    out_y <= rd_data;
            3'd3:    out_w <= rd_data;
            3'd4:    out_h <= rd_data;
            default: ;
          endcase
          if (k == 3'd4) begin
            rd_en <= 1'b0;
            state <= LAST;
          end else begin
            rd_addr <= rd_addr + AW'(1);
            k       <= k + 3'd1;
          end
        end
        LAST: begin
          out_obj <= rd_data;
          state   <= CHECK;
        end
        CHECK: begin
          if (pass) begin
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cand_count != '1) cand_count <= cand_count + 16'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (do_adv) begin
        if (last_box) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end else begin
          out_box  <= nxt_b;
          out_cx   <= nxt_cx;
          out_cy   <= nxt_cy;
          box_addr <= box_addr + STRIDE;
          rd_addr  <= box_addr + STRIDE;
          rd_en    <= 1'b1;
          k        <= '0;
          state    <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_detection_scheduler.sv
// Randomized bench for detection_scheduler on a 2x2 grid, 2 anchors, 1 class,
// checked against a per-frame list of expected reads and candidate records.
module tb_detection_scheduler;

  localparam int GW = 2, GH = 2, NB = 2, NC = 1, DW = 16, AW = 16;
  localparam int STRIDE = 5 + NC;
  localparam int NBOX = GW * GH * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] obj_thresh = '0;
  logic          busy, done, rd_en, out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] out_x, out_y, out_w, out_h, out_obj;
  logic [7:0]    out_cx, out_cy, out_box;
  logic [15:0]   cand_count;

  detection_scheduler #(.GRID_W(GW), .GRID_H(GH), .B(NB), .C(NC), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .obj_thresh(obj_thresh), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_w(out_w),
    .out_h(out_h), .out_obj(out_obj), .out_cx(out_cx), .out_cy(out_cy),
    .out_box(out_box), .cand_count(cand_count)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [103:0] payload();
    return {out_x, out_y, out_w, out_h, out_obj, out_cx, out_cy, out_box};
  endfunction

  function automatic logic [15:0] box_base(input logic [15:0] base, input int idx);
    return base + 16'(idx * STRIDE);
  endfunction

  // obj_mode: 0 all -1, 1 all 0x7FFF, 2 random
  task automatic fill(input logic [15:0] base, input int obj_mode);
    logic [15:0] a;
    for (int i = 0; i < NBOX * STRIDE; i++) begin
      a = base + 16'(i);
      mem[a] = 16'($urandom);
    end
    for (int i = 0; i < NBOX; i++) begin
      a = box_base(base, i) + 16'd4;
      case (obj_mode)
        0:       mem[a] = 16'hFFFF;
        1:       mem[a] = 16'h7FFF;
        default: mem[a] = 16'($urandom);
      endcase
    end
  endtask

  // rmode: 0 always ready, 1 random ready, 2 three stall cycles on the 2nd record
  task automatic run_frame(input logic [15:0] base, input logic [15:0] thr,
                           input int rmode, input bit chaos);
    logic [103:0] exp_q[$];
    logic [15:0]  exp_addr[$];
    logic [15:0]  a0, ea;
    logic [104:0] cur, held;
    bit           held_stall, seen_done;
    int           cyc, stalls, addr_err, popped, stall_run, nacc;

    for (int cy = 0; cy < GH; cy++)
      for (int cx = 0; cx < GW; cx++)
        for (int b = 0; b < NB; b++) begin
          a0 = box_base(base, (cy * GW + cx) * NB + b);
          for (int k = 0; k < 5; k++) exp_addr.push_back(a0 + 16'(k));
          if ($signed(mem[a0 + 16'd4]) >= $signed(thr))
            exp_q.push_back({mem[a0], mem[a0 + 16'd1], mem[a0 + 16'd2], mem[a0 + 16'd3],
                             mem[a0 + 16'd4], 8'(cx), 8'(cy), 8'(b)});
        end
    nacc = exp_q.size();

    @(negedge clk);
    base_addr = base; obj_thresh = thr; start = 1'b1;
    cyc = 1; stalls = 0; addr_err = 0; popped = 0; stall_run = 0;
    held_stall = 0; seen_done = 0; held = '0;
    for (int n = 0; n < 3000 && !seen_done; n++) begin
      @(negedge clk);
      cyc++;
      if (n == 0) check("busy_after_start", busy, 1);
      start = 1'b0;
      if (chaos && !done && $urandom_range(0, 5) == 0) begin
        start = 1'b1; base_addr = 16'($urandom); obj_thresh = 16'($urandom);
      end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(popped == 1 && stall_run < 3);
      endcase
      cur = {out_valid, payload()};
      if (held_stall) check("hold", cur, held);
      if (rd_en) begin
        if (exp_addr.size() == 0) addr_err++;
        else begin
          ea = exp_addr.pop_front();
          if (rd_addr !== ea) addr_err++;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_rec", 1, 0);
        else check("rec", payload(), exp_q.pop_front());
        popped++; stall_run = 0; held_stall = 0;
      end else if (out_valid) begin
        stalls++; stall_run++; held_stall = 1; held = cur;
      end else held_stall = 0;
      if (done) begin
        seen_done = 1;
        check("frame_cycles", cyc, 2 + 7 * NBOX + nacc + stalls);
        check("busy_in_done", busy, 0);
        check("cand_count", cand_count, nacc);
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    check("addr_err", addr_err, 0);
    check("addr_left", exp_addr.size(), 0);
    check("rec_left", exp_q.size(), 0);
    @(negedge clk);
    start = 1'b0;
    check("done_width", done, 0);
    out_ready = 1'b0;
  endtask

  function automatic logic [127:0] all_outs();
    return {busy, done, rd_en, rd_addr, out_valid, payload(), cand_count};
  endfunction

  initial begin
    bit got_valid;
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", all_outs(), '0);

    // no box passes: address pattern and 58-cycle frame
    fill(16'h0100, 0);
    run_frame(16'h0100, 16'h0000, 0, 0);

    // single candidate: cell(1,0) box 1, objectness equal to threshold
    fill(16'h0100, 0);
    mem[16'h0116] = 16'h0000;
    run_frame(16'h0100, 16'h0000, 0, 0);

    // every box passes, stall on the 2nd record, start/thresh churn while busy
    fill(16'h0100, 1);
    run_frame(16'h0100, 16'h0000, 2, 1);

    // signed compare: -1 >= -2 passes, 0x8000 does not
    fill(16'h0300, 0);
    mem[box_base(16'h0300, 5) + 16'd4] = 16'h8000;
    run_frame(16'h0300, 16'hFFFE, 1, 0);

    // reset while a record waits for out_ready
    fill(16'h0200, 1);
    @(negedge clk);
    base_addr = 16'h0200; obj_thresh = 16'h0000; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    got_valid = 0;
    for (int n = 0; n < 50 && !got_valid; n++) begin
      @(negedge clk);
      got_valid = out_valid;
    end
    check("emit_reached", got_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", all_outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_abort", {done, busy}, 2'b00);
    end
    run_frame(16'h0200, 16'h0000, 1, 0);

    // random frames, including base addresses that wrap the address space
    for (int f = 0; f < 6; f++) begin
      logic [15:0] base;
      base = (f == 0) ? 16'hFFF0 : 16'($urandom);
      fill(base, 2);
      run_frame(base, 16'($urandom), 1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
